// File: rtl/turbo_rsc_stream_checker.sv
// turbo_rsc_stream_checker: packs received systematic bits into bytes and re-encodes them through the constituent-1 RSC to check parity and tail.
// Build option TURBO_CHK_ERR_CNT_EN: full saturating mismatch count on err_count; otherwise a sticky flag and err_count=0.
module turbo_rsc_stream_checker #(
   parameter int FRAME_LEN = 40,
   parameter int CNT_W     = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_sys,
   input  logic             in_par,
   output logic [7:0]       data_out,
   output logic             data_valid,
   output logic             frame_done,
   output logic             frame_err,
   output logic [CNT_W-1:0] err_count
);
`ifdef TURBO_CHK_ERR_CNT_EN
   localparam int EW = CNT_W;
   logic [CNT_W-1:0] ec_q, ec_d;
`else
   localparam int EW = 1;
`endif
   typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;
   state_t           st_q, st_d;
   logic [2:0]       s_q, s_d, s_use;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_use;
   logic [EW-1:0]    err_q, err_d, err_use;
   logic [EW:0]      sum;
   logic [7:0]       sh_q, sh_d, dout_q, dout_d;
   logic             dv_q, dv_d, fd_q, fd_d, fe_q, fe_d;
   logic             tail, u, fb, p_exp;
   logic [1:0]       mis;
   always_comb begin
      st_d    = st_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      sh_d    = sh_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      fd_d    = 1'b0;
      fe_d    = fe_q;
`ifdef TURBO_CHK_ERR_CNT_EN
      ec_d    = ec_q;
`endif
      // DONE acts as a fresh start so a pair arriving in that cycle opens the next frame
      s_use   = (st_q == DONE) ? 3'd0 : s_q;
      cnt_use = (st_q == DONE) ? '0 : cnt_q;
      err_use = (st_q == DONE) ? '0 : err_q;
      tail    = (st_q == TAIL);
      u       = tail ? (s_use[1] ^ s_use[2]) : in_sys;
      fb      = u ^ s_use[1] ^ s_use[2];
      p_exp   = fb ^ s_use[0] ^ s_use[2];
      mis     = {1'b0, in_par != p_exp} + {1'b0, tail && (in_sys != u)};
      sum     = {1'b0, err_use} + (EW+1)'(mis);
      if (st_q == DONE) begin
         st_d  = IDLE;
         s_d   = '0;
         cnt_d = '0;
         err_d = '0;
      end
      if (in_valid) begin
         s_d   = {s_use[1:0], fb};
         err_d = sum[EW] ? '1 : sum[EW-1:0];
         if (tail) begin
            cnt_d = (cnt_use == CNT_W'(2)) ? '0 : cnt_use + 1'b1;
            st_d  = (cnt_use == CNT_W'(2)) ? DONE : TAIL;
            fd_d  = (cnt_use == CNT_W'(2));
            fe_d  = fd_d ? (err_d != '0) : fe_q;
`ifdef TURBO_CHK_ERR_CNT_EN
            ec_d  = fd_d ? err_d : ec_q;
`endif
         end else begin
            sh_d   = {in_sys, sh_q[7:1]};
            dv_d   = (cnt_use[2:0] == 3'd7);
            dout_d = dv_d ? sh_d : dout_q;
            cnt_d  = (cnt_use == CNT_W'(FRAME_LEN - 1)) ? '0 : cnt_use + 1'b1;
            st_d   = (cnt_use == CNT_W'(FRAME_LEN - 1)) ? TAIL : DATA;
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q   <= IDLE;
         s_q    <= '0;
         cnt_q  <= '0;
         err_q  <= '0;
         sh_q   <= '0;
         dout_q <= '0;
         dv_q   <= 1'b0;
         fd_q   <= 1'b0;
         fe_q   <= 1'b0;
`ifdef TURBO_CHK_ERR_CNT_EN
         ec_q   <= '0;
`endif
      end else begin
         st_q   <= st_d;
         s_q    <= s_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         sh_q   <= sh_d;
         dout_q <= dout_d;
         dv_q   <= dv_d;
         fd_q   <= fd_d;
         fe_q   <= fe_d;
`ifdef TURBO_CHK_ERR_CNT_EN
         ec_q   <= ec_d;
`endif
      end
   end
   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign frame_done = fd_q;
   assign frame_err  = fe_q;
`ifdef TURBO_CHK_ERR_CNT_EN
   assign err_count  = ec_q;
`else
   assign err_count  = '0;
`endif
endmodule

// File: tb/tb_turbo_rsc_stream_checker.sv
// tb_turbo_rsc_stream_checker: directed and random frames against a polynomial-form turbo RSC model.
module tb_turbo_rsc_stream_checker;
   localparam int FL = 40;
   localparam int CW = 13;
   localparam int N  = FL + 3;
   logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sys = 1'b0, in_par = 1'b0;
   logic [7:0]    data_out;
   logic          data_valid, frame_done, frame_err;
   logic [CW-1:0] err_count;
   int            checks = 0, errors = 0;
   logic [7:0]    bq[$];
   logic [CW:0]   fq[$];
   bit            d[FL];
   bit            ts[N], tp[N], cs[N], cp[N];
   int            n_flip;
   always #5 clk = ~clk;
   turbo_rsc_stream_checker #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sys(in_sys), .in_par(in_par),
      .data_out(data_out), .data_valid(data_valid), .frame_done(frame_done),
      .frame_err(frame_err), .err_count(err_count)
   );
   always @(negedge clk) begin
      if (data_valid) bq.push_back(data_out);
      if (frame_done) fq.push_back({frame_err, err_count});
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // a[k] is the feedback sequence: a = u + D^2 a + D^3 a ; p = a + D a + D^3 a
   task automatic encode();
      bit a[N+3];
      bit uk, ak;
      foreach (a[i]) a[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
         uk = (k < FL) ? d[k] : (a[k+1] ^ a[k]);
         ak = uk ^ a[k+1] ^ a[k];
         a[k+3] = ak;
         ts[k] = uk;
         tp[k] = ak ^ a[k+2] ^ a[k];
         cs[k] = ts[k];
         cp[k] = tp[k];
      end
   endtask
   function automatic int count_flips();
      int n = 0;
      for (int k = 0; k < N; k++) begin
         n += int'(tp[k] != cp[k]);
         if (k >= FL) n += int'(ts[k] != cs[k]);
      end
      return n;
   endfunction
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask
   task automatic send(input int npairs, input int gap);
      for (int k = 0; k < npairs; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_sys   = ts[k];
         in_par   = tp[k];
         if (gap > 0) idle(gap);
      end
   endtask
   task automatic check_frames(input string tag, input int nfr);
      logic [7:0]    eb;
      logic [CW-1:0] ec;
      int            b;
`ifdef TURBO_CHK_ERR_CNT_EN
      ec = CW'(n_flip);
`else
      ec = '0;
`endif
      chk({tag, " nbytes"}, bq.size(), nfr * FL / 8);
      chk({tag, " nframes"}, fq.size(), nfr);
      for (int i = 0; i < bq.size() && i < nfr * FL / 8; i++) begin
         b = i % (FL / 8);
         for (int j = 0; j < 8; j++) eb[j] = d[b*8+j];
         chk($sformatf("%s byte%0d", tag, i), bq[i], eb);
      end
      for (int i = 0; i < fq.size() && i < nfr; i++) begin
         chk($sformatf("%s frame_err%0d", tag, i), fq[i][CW], n_flip != 0);
         chk($sformatf("%s err_count%0d", tag, i), fq[i][CW-1:0], ec);
      end
      bq.delete();
      fq.delete();
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst data_out", data_out, 0);
      chk("rst data_valid", data_valid, 0);
      chk("rst frame_done", frame_done, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst err_count", err_count, 0);
      reset = 1'b0;
      idle(2);
      foreach (d[i]) d[i] = 1'b0;
      encode();
      n_flip = count_flips();
      send(N, 0); idle(4);
      check_frames("T1", 1);
      foreach (d[i]) d[i] = ~i[0];
      encode();
      n_flip = count_flips();
      send(N, 0); idle(4);
      chk("T2 byte55", {24'd0, d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]}, 32'hAA);
      check_frames("T2", 1);
      tp[5] = ~tp[5];
      n_flip = count_flips();
      send(N, 0); idle(4);
      check_frames("T3", 1);
      encode();
      n_flip = count_flips();
      send(N, 6); idle(4);
      check_frames("T4", 1);
      foreach (d[i]) d[i] = 1'b0;
      encode();
      n_flip = count_flips();
      send(N, 0); send(N, 0); idle(4);
      check_frames("T5", 2);
      foreach (d[i]) d[i] = ~i[0];
      encode();
      n_flip = count_flips();
      send(20, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("T6 pre-reset bytes", bq.size(), 2);
      bq.delete();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("T6 reset data_valid", data_valid, 0);
      chk("T6 reset strobes", bq.size() + fq.size(), 0);
      reset = 1'b0;
      idle(2);
      send(N, 0); idle(4);
      check_frames("T6", 1);
      for (int r = 0; r < 10; r++) begin
         int nf, g, nfr;
         foreach (d[i]) d[i] = bit'($urandom_range(1));
         encode();
         nf = $urandom_range(3);
         for (int f = 0; f < nf; f++) begin
            int p = $urandom_range(N - 1);
            if ($urandom_range(1) == 1 && p >= FL) ts[p] = ~ts[p];
            else tp[p] = ~tp[p];
         end
         n_flip = count_flips();
         g = $urandom_range(2);
         nfr = 1 + $urandom_range(1);
         repeat (nfr) send(N, g);
         idle(4);
         check_frames($sformatf("R%0d", r), nfr);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
